// File: rtl/uart_ram_loader.sv
// uart_ram_loader: parses framed UART bytes into memory-bus writes and replies with a checksum status byte
module uart_ram_loader #(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        hwclk,
    input  logic        reset,
    input  logic [7:0]  rxdata,
    input  logic        rxready,
    output logic        rxclk,
    output logic [7:0]  txdata,
    input  logic        txready,
    output logic        txclk,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_read_en,
    output logic        busy,
    output logic        done,
    output logic        error
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, LEN, DATA, WRITE, CHECK, SEND} state_t;
    state_t state, state_nx;
    logic hold2, accept, timed, timeout;
    logic [15:0] ptr;
    logic [8:0] cnt;
    logic [7:0] sum, data, status;
    logic [TW-1:0] tcnt;
    // rxclk and hold2 blank the two cycles after a pop while the UART refreshes rxready
    assign accept = rxready && !rxclk && !hold2 && state != WRITE && state != SEND;
    assign timed = state != IDLE && state != WRITE && state != SEND;
    assign timeout = timed && !accept && tcnt == TW'(TIMEOUT_CYCLES - 1);
    assign busy = state != IDLE;
    assign mem_read_en = state != WRITE;
    assign mem_addr = ptr;
    assign mem_wdata = state == WRITE ? data : 8'h00;
    assign txdata = status;
    assign txclk = state == SEND && txready;
    assign done = txclk;
    assign error = txclk && status != 8'h4B;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && rxdata == SYNC_BYTE) state_nx = ADDR_HI;
            ADDR_HI: if (accept) state_nx = ADDR_LO;
            ADDR_LO: if (accept) state_nx = LEN;
            LEN:     if (accept) state_nx = DATA;
            DATA:    if (accept) state_nx = WRITE;
            WRITE:   state_nx = cnt == 9'd1 ? CHECK : DATA;
            CHECK:   if (accept) state_nx = SEND;
            SEND:    if (txready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (timeout) state_nx = SEND;
    end
    always_ff @(posedge hwclk) begin
        state <= reset ? IDLE : state_nx;
    end
    always_ff @(posedge hwclk) begin
        if (reset) begin
            rxclk <= 1'b0;
            hold2 <= 1'b0;
            ptr <= 16'd0;
            cnt <= 9'd0;
            sum <= 8'd0;
            data <= 8'd0;
            status <= 8'd0;
            tcnt <= '0;
        end else begin
            rxclk <= accept;
            hold2 <= rxclk;
            tcnt <= (accept || !timed) ? '0 : tcnt + TW'(1);
            if (accept) begin
                case (state)
                    IDLE:    sum <= 8'd0;
                    ADDR_HI: ptr[15:8] <= rxdata;
                    ADDR_LO: ptr[7:0] <= rxdata;
                    LEN:     cnt <= {rxdata == 8'd0, rxdata};
                    DATA:    data <= rxdata;
                    CHECK:   status <= rxdata == sum ? 8'h4B : 8'h45;
                    default: ;
                endcase
            end
            if (state == WRITE) begin
                sum <= sum + data;
                ptr <= ptr + 16'd1;
                cnt <= cnt - 9'd1;
            end
            if (timeout) status <= 8'h54;
        end
    end
endmodule

// File: tb/tb_uart_ram_loader.sv
// tb_uart_ram_loader: directed and randomized frames checked every cycle against a frame-level model
module tb_uart_ram_loader;
    localparam int TO = 16;
    localparam logic [7:0] SYNC = 8'hA5;
    logic hwclk = 1'b0, reset = 1'b1;
    logic [7:0] rxdata = 8'h00;
    logic rxready = 1'b0, txready = 1'b1;
    logic rxclk, txclk, mem_read_en, busy, done, error;
    logic [7:0] txdata, mem_wdata;
    logic [15:0] mem_addr;
    int vectors = 0, miscompares = 0;
    bit rand_tx = 0, tx_force = 1;
    logic [7:0] popq[$];
    logic [7:0] seen[int];
    int n_wr = 0, n_pop = 0, frames_done = 0, cyc = 0, last_pop_cyc = 0, last_tx_cyc = 0;
    logic [7:0] last_tx = 8'h00;
    logic last_err = 1'b0;

    uart_ram_loader #(.TIMEOUT_CYCLES(TO), .SYNC_BYTE(SYNC)) dut (
        .hwclk(hwclk), .reset(reset), .rxdata(rxdata), .rxready(rxready), .rxclk(rxclk),
        .txdata(txdata), .txready(txready), .txclk(txclk), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_read_en(mem_read_en), .busy(busy), .done(done), .error(error)
    );

    always #5 hwclk = ~hwclk;

    initial forever begin
        @(posedge hwclk);
        #1;
        txready = rand_tx ? ($urandom_range(0, 3) != 0) : tx_force;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [15:0] got_mem(input int k);
        return seen.exists(k) ? {8'h00, seen[k]} : 16'hDEAD;
    endfunction

    // Frame-level reference: parses each popped byte and predicts bus writes, busy and status
    bit in_frame = 0, tx_pend = 0, tx_arm = 0, exp_wr = 0;
    int stage = 0, remain = 0, idle_run = 0;
    logic [15:0] ptr = 16'h0000, wr_addr = 16'h0000;
    logic [7:0] sum = 8'h00, tx_stat = 8'h00, wr_data = 8'h00, b;
    always @(negedge hwclk) begin
        cyc++;
        if (reset) begin
            in_frame = 0; tx_pend = 0; tx_arm = 0; stage = 0; ptr = 16'h0000; idle_run = 0;
            popq.delete();
        end else begin
            exp_wr = 0;
            if (tx_arm) begin tx_pend = 1; tx_arm = 0; end
            if (rxclk) begin
                n_pop++;
                last_pop_cyc = cyc;
                chk("rxclk_without_byte", 32'(popq.size() != 0), 1);
                if (popq.size() != 0) begin
                    b = popq.pop_front();
                    if (!in_frame) begin
                        if (b == SYNC) begin in_frame = 1; stage = 0; sum = 8'h00; idle_run = 1; end
                    end else begin
                        idle_run = 1;
                        case (stage)
                            0: ptr[15:8] = b;
                            1: ptr[7:0] = b;
                            2: remain = (b == 8'h00) ? 256 : int'(b);
                            3: begin
                                exp_wr = 1; wr_addr = ptr; wr_data = b;
                                sum += b; ptr++; remain--; idle_run = 0;
                            end
                            default: begin tx_pend = 1; tx_stat = (b == sum) ? 8'h4B : 8'h45; end
                        endcase
                        stage = (stage == 3 && remain > 0) ? 3 : stage + 1;
                    end
                end
            end else if (in_frame && !tx_pend && !tx_arm) idle_run++;
            if (in_frame && !tx_pend && !tx_arm && idle_run >= TO) begin tx_arm = 1; tx_stat = 8'h54; end
            chk("mem_read_en", 32'(mem_read_en), 32'(!exp_wr));
            chk("mem_addr", 32'(mem_addr), 32'(exp_wr ? wr_addr : ptr));
            chk("mem_wdata", 32'(mem_wdata), 32'(exp_wr ? wr_data : 8'h00));
            if (!mem_read_en) begin seen[int'(mem_addr)] = mem_wdata; n_wr++; end
            chk("busy", 32'(busy), 32'(in_frame));
            chk("txclk", 32'(txclk), 32'(tx_pend && txready));
            chk("done", 32'(done), 32'(tx_pend && txready));
            chk("error", 32'(error), 32'(tx_pend && txready && tx_stat != 8'h4B));
            if (tx_pend) chk("txdata", 32'(txdata), 32'(tx_stat));
            if (txclk) begin last_tx = txdata; last_err = error; last_tx_cyc = cyc; frames_done++; end
            if (tx_pend && txready) begin tx_pend = 0; in_frame = 0; stage = 0; end
        end
    end

    task automatic step;
        @(posedge hwclk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap);
        int t = 0;
        repeat (gap) step();
        rxdata = v;
        rxready = 1'b1;
        popq.push_back(v);
        do begin step(); t++; end while (!rxclk && t < 12);
        if (!rxclk) begin
            chk("rx_pop_timeout", 32'(rxclk), 1);
            void'(popq.pop_back());
        end
        rxready = 1'b0;
    endtask

    task automatic send_seq(input logic [63:0] v, input int n, input int gmax);
        for (int i = n - 1; i >= 0; i--) send_byte(v[8*i +: 8], $urandom_range(0, gmax));
    endtask

    task automatic wait_done(input int target, input int limit);
        int t = 0;
        while (frames_done < target && t < limit) begin step(); t++; end
        chk("frame_done_seen", 32'(frames_done >= target), 1);
    endtask

    task automatic check_reset;
        chk("rst_rxclk", 32'(rxclk), 0);
        chk("rst_txclk", 32'(txclk), 0);
        chk("rst_txdata", 32'(txdata), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_mem_read_en", 32'(mem_read_en), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
    endtask

    initial begin
        int fd, len;
        logic [15:0] a;
        logic [7:0] s, v;
        repeat (3) step();
        check_reset();
        reset = 1'b0;
        step();

        n_wr = 0; seen.delete(); fd = frames_done;
        send_seq(64'hA5_00_10_03_11_22_33_66, 8, 1);
        wait_done(fd + 1, 100);
        chk("A_mem_0010", 32'(got_mem(16'h0010)), 32'h11);
        chk("A_mem_0011", 32'(got_mem(16'h0011)), 32'h22);
        chk("A_mem_0012", 32'(got_mem(16'h0012)), 32'h33);
        chk("A_writes", n_wr, 3);
        chk("A_tx", 32'(last_tx), 32'h4B);
        chk("A_err", 32'(last_err), 0);
        chk("A_busy_after", 32'(busy), 0);

        n_wr = 0; fd = frames_done;
        send_seq(64'hA5_00_20_01_55_00, 6, 1);
        wait_done(fd + 1, 100);
        chk("B_mem_0020", 32'(got_mem(16'h0020)), 32'h55);
        chk("B_tx", 32'(last_tx), 32'h45);
        chk("B_err", 32'(last_err), 1);

        n_wr = 0; n_pop = 0; fd = frames_done;
        send_seq(64'h00_FF_5A, 3, 1);
        repeat (3) step();
        chk("C_junk_pops", n_pop, 3);
        chk("C_junk_writes", n_wr, 0);
        chk("C_junk_busy", 32'(busy), 0);
        send_seq(64'hA5_12_34_02_01_02_03, 7, 1);
        wait_done(fd + 1, 100);
        chk("C_mem_1234", 32'(got_mem(16'h1234)), 32'h01);
        chk("C_mem_1235", 32'(got_mem(16'h1235)), 32'h02);
        chk("C_tx", 32'(last_tx), 32'h4B);

        n_wr = 0; seen.delete(); fd = frames_done;
        send_seq(64'hA5_FF_FF_00, 4, 0);
        repeat (256) send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        wait_done(fd + 1, 100);
        chk("D_writes", n_wr, 256);
        chk("D_mem_FFFF", 32'(got_mem(16'hFFFF)), 32'h01);
        chk("D_mem_0000", 32'(got_mem(16'h0000)), 32'h01);
        chk("D_mem_00FE", 32'(got_mem(16'h00FE)), 32'h01);
        chk("D_mem_00FF_untouched", 32'(got_mem(16'h00FF)), 32'hDEAD);
        chk("D_tx", 32'(last_tx), 32'h4B);

        n_wr = 0; fd = frames_done;
        send_seq(64'hA5_00_00, 3, 1);
        wait_done(fd + 1, 100);
        chk("E_tx", 32'(last_tx), 32'h54);
        chk("E_err", 32'(last_err), 1);
        chk("E_writes", n_wr, 0);
        chk("E_timeout_latency", last_tx_cyc - last_pop_cyc, 16);

        tx_force = 0; fd = frames_done;
        send_seq(64'hA5_00_00, 3, 1);
        repeat (50) step();
        chk("F_no_tx_while_stalled", frames_done, fd);
        chk("F_busy_held", 32'(busy), 1);
        chk("F_txclk_low", 32'(txclk), 0);
        chk("F_txdata_held", 32'(txdata), 32'h54);
        tx_force = 1;
        wait_done(fd + 1, 20);
        chk("F_tx", 32'(last_tx), 32'h54);
        chk("F_err", 32'(last_err), 1);

        n_wr = 0; fd = frames_done;
        send_seq(64'hA5_01_00_04_AA_BB, 6, 1);
        step();
        reset = 1'b1;
        step();
        check_reset();
        chk("G_partial_writes", n_wr, 2);
        reset = 1'b0;
        step();
        chk("G_no_tx", frames_done, fd);
        send_seq(64'hA5_01_00_02_CC_DD_A9, 7, 1);
        wait_done(fd + 1, 100);
        chk("G_mem_0100", 32'(got_mem(16'h0100)), 32'hCC);
        chk("G_mem_0101", 32'(got_mem(16'h0101)), 32'hDD);
        chk("G_tx", 32'(last_tx), 32'h4B);

        rand_tx = 1;
        for (int k = 0; k < 30; k++) begin
            repeat ($urandom_range(0, 2)) begin
                v = 8'($urandom_range(0, 255));
                if (v == SYNC) v = 8'h00;
                send_byte(v, $urandom_range(0, 3));
            end
            a = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 6)) : 16'($urandom);
            len = $urandom_range(1, 10);
            s = 8'h00;
            fd = frames_done;
            send_seq({32'h0, SYNC, a, 8'(len)}, 4, 3);
            repeat (len) begin
                v = 8'($urandom);
                s += v;
                send_byte(v, $urandom_range(0, 4));
            end
            send_byte(($urandom_range(0, 2) == 0) ? s ^ 8'($urandom_range(1, 255)) : s, $urandom_range(0, 4));
            wait_done(fd + 1, 300);
        end
        rand_tx = 0;
        repeat (4) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
